// File: rtl/bwd_prop_out_if.sv
// Handshake and data bundle between the DQN controller and the
// backward-propagation engine.
interface bwd_prop_out_if #(
  parameter int NH = 5,
  parameter int NO = 4
);
  logic                   start;
  logic [$clog2(NO)-1:0]  action;
  logic [15:0]            target;
  logic [15:0]            lr;
  logic [16*NO-1:0]       a3_flat;
  logic [16*NH-1:0]       a2_flat;
  logic [16*NH*NO-1:0]    w3_flat;
  logic [16*NH*NO-1:0]    deltaw3_flat;
  logic [16*NO-1:0]       deltab3_flat;
  logic [16*NH-1:0]       deltab2_flat;
  logic                   busy;
  logic                   done;

  modport master (
    output start, action, target, lr,
    output a3_flat, a2_flat, w3_flat,
    input  deltaw3_flat, deltab3_flat,
    input  deltab2_flat, busy, done
  );

  modport slave (
    input  start, action, target, lr,
    input  a3_flat, a2_flat, w3_flat,
    output deltaw3_flat, deltab3_flat,
    output deltab2_flat, busy, done
  );
endinterface

// File: rtl/bwd_prop_out.sv
// Backward pass for the DQN output layer: TD error, scaled delta,
// then a serial loop over hidden neurons producing w3/b3/b2 deltas.
module bwd_prop_out #(
  parameter int NH   = 5,
  parameter int NO   = 4,
  parameter int FRAC = 10
) (
  input  logic clk,
  input  logic rst,
  bwd_prop_out_if.slave bus
);

  localparam int AW = $clog2(NO);
  localparam int IW = $clog2(NH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERR,
    S_SCALE,
    S_LOOP,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic        [AW-1:0] r_action;
  logic signed [15:0]   r_target;
  logic signed [15:0]   r_lr;
  logic signed [15:0]   r_a3;
  logic signed [15:0]   r_err;
  logic signed [15:0]   r_delta;
  logic        [IW-1:0] r_idx;
  logic signed [15:0]   r_a2  [NH];
  logic signed [15:0]   r_w3c [NH];
  logic signed [15:0]   r_dw3 [NH][NO];
  logic signed [15:0]   r_db3 [NO];
  logic signed [15:0]   r_db2 [NH];

  logic                 w_accept;
  logic signed [15:0]   w_a3sel;
  logic signed [15:0]   w_w3c [NH];
  logic signed [16:0]   w_diff;
  logic signed [15:0]   w_err;
  logic signed [15:0]   w_a2i;
  logic signed [15:0]   w_w3i;
  logic signed [15:0]   w_ma;
  logic signed [15:0]   w_mb;
  logic signed [31:0]   w_p1;
  logic signed [31:0]   w_p2;
  logic signed [15:0]   w_s1;
  logic signed [15:0]   w_s2;

  function automatic logic signed [15:0] f_sat(
    input logic signed [31:0] p
  );
    logic signed [31:0] s;
    s = p >>> FRAC;
    if ((&s[31:15]) || !(|s[31:15]))
      return s[15:0];
    return p[31] ? 16'sh8000 : 16'sh7fff;
  endfunction

  // DONE also accepts start so passes can run back to back.
  assign w_accept = bus.start &&
    ((r_state == S_IDLE) || (r_state == S_DONE));

  assign w_a3sel = bus.a3_flat[16*bus.action +: 16];

  always_comb begin
    for (int i = 0; i < NH; i++)
      w_w3c[i] = bus.w3_flat[16*(NO*i + int'(bus.action)) +: 16];
  end

  assign w_diff = {r_target[15], r_target} - {r_a3[15], r_a3};

  always_comb begin
    w_err = w_diff[15:0];
    if (w_diff[16] != w_diff[15])
      w_err = w_diff[16] ? 16'sh8000 : 16'sh7fff;
  end

  always_comb begin
    w_a2i = '0;
    w_w3i = '0;
    for (int i = 0; i < NH; i++) begin
      if (r_idx == IW'(i)) begin
        w_a2i = r_a2[i];
        w_w3i = r_w3c[i];
      end
    end
  end

  // Multiplier 1 is shared between the lr scaling and the w3 deltas.
  assign w_ma = (r_state == S_SCALE) ? r_err : r_delta;
  assign w_mb = (r_state == S_SCALE) ? r_lr  : w_a2i;
  assign w_p1 = w_ma * w_mb;
  assign w_p2 = w_w3i * r_delta;
  assign w_s1 = f_sat(w_p1);
  assign w_s2 = f_sat(w_p2);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ERR;
      S_ERR:   w_next = S_SCALE;
      S_SCALE: w_next = S_LOOP;
      S_LOOP:  if (r_idx == IW'(NH-1)) w_next = S_DONE;
      S_DONE:  w_next = w_accept ? S_ERR : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_action <= '0;
      r_target <= '0;
      r_lr     <= '0;
      r_a3     <= '0;
      r_err    <= '0;
      r_delta  <= '0;
      r_idx    <= '0;
      for (int i = 0; i < NH; i++) begin
        r_a2[i]  <= '0;
        r_w3c[i] <= '0;
        r_db2[i] <= '0;
        for (int j = 0; j < NO; j++)
          r_dw3[i][j] <= '0;
      end
      for (int j = 0; j < NO; j++)
        r_db3[j] <= '0;
    end else if (w_accept) begin
      r_action <= bus.action;
      r_target <= bus.target;
      r_lr     <= bus.lr;
      r_a3     <= w_a3sel;
      r_idx    <= '0;
      for (int i = 0; i < NH; i++) begin
        r_a2[i]  <= bus.a2_flat[16*i +: 16];
        r_w3c[i] <= w_w3c[i];
        r_db2[i] <= '0;
        for (int j = 0; j < NO; j++)
          r_dw3[i][j] <= '0;
      end
      for (int j = 0; j < NO; j++)
        r_db3[j] <= '0;
    end else begin
      unique case (r_state)
        S_ERR: r_err <= w_err;
        S_SCALE: begin
          r_delta         <= w_s1;
          r_db3[r_action] <= w_s1;
          r_idx           <= '0;
        end
        S_LOOP: begin
          for (int i = 0; i < NH; i++) begin
            if (r_idx == IW'(i)) begin
              r_dw3[i][r_action] <= w_s1;
              // ReLU derivative: a2 of zero is inactive.
              r_db2[i] <= (r_a2[i] > 16'sd0) ? w_s2 : 16'sd0;
            end
          end
          r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.deltaw3_flat = '0;
    bus.deltab3_flat = '0;
    bus.deltab2_flat = '0;
    for (int i = 0; i < NH; i++) begin
      bus.deltab2_flat[16*i +: 16] = r_db2[i];
      for (int j = 0; j < NO; j++)
        bus.deltaw3_flat[16*(NO*i+j) +: 16] = r_dw3[i][j];
    end
    for (int j = 0; j < NO; j++)
      bus.deltab3_flat[16*j +: 16] = r_db3[j];
  end

  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = (r_state == S_DONE);

endmodule

// File: tb/tb_bwd_prop_out.sv
// Directed checks for bwd_prop_out: nominal pass, gating, saturation,
// busy starts, mid-pass reset and back-to-back passes.
module tb_bwd_prop_out;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   np;
  int   fe;
  logic [319:0] exp_w3;
  logic [79:0]  exp_b2;
  logic [63:0]  exp_b3;

  bwd_prop_out_if #(.NH(5), .NO(4)) bus ();

  bwd_prop_out #(.NH(5), .NO(4), .FRAC(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [319:0] obs,
                     input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] dw3(input int i, input int j);
    return bus.deltaw3_flat[16*(4*i+j) +: 16];
  endfunction

  task automatic clr_inputs();
    bus.start   = 1'b0;
    bus.action  = '0;
    bus.target  = '0;
    bus.lr      = '0;
    bus.a3_flat = '0;
    bus.a2_flat = '0;
    bus.w3_flat = '0;
  endtask

  task automatic nominal_inputs();
    clr_inputs();
    bus.action = 2'd1;
    bus.target = 16'd2048;
    bus.lr     = 16'd512;
    bus.a3_flat[16 +: 16] = 16'd1024;
    bus.a2_flat = {16'd2048, 16'd256, 16'd0, 16'd512, 16'd1024};
    bus.w3_flat[16*1 +: 16] = 16'd2048;
    bus.w3_flat[16*5 +: 16] = 16'd1024;
  endtask

  task automatic start_pass();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Runs n edges after the start edge; s1/s2 assert start, rk asserts rst.
  task automatic watch(input int n, input int s1, input int s2,
                       input int rk, output int npulse,
                       output int first);
    npulse = 0;
    first  = -1;
    for (int k = 1; k <= n; k++) begin
      bus.start = (k == s1) || (k == s2);
      rst       = (k == rk);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      rst       = 1'b0;
      if (bus.done) begin
        npulse++;
        if (first < 0) first = k;
      end
    end
  endtask

  task automatic chk_nominal(input string p);
    exp_w3 = '0;
    exp_w3[16*1  +: 16] = 16'd512;
    exp_w3[16*5  +: 16] = 16'd256;
    exp_w3[16*13 +: 16] = 16'd128;
    exp_w3[16*17 +: 16] = 16'd1024;
    exp_b3 = '0;
    exp_b3[16 +: 16] = 16'd512;
    exp_b2 = {16'd0, 16'd0, 16'd0, 16'd512, 16'd1024};
    chk({p, "_dw3"}, bus.deltaw3_flat, exp_w3);
    chk({p, "_db3"}, bus.deltab3_flat, exp_b3);
    chk({p, "_db2"}, bus.deltab2_flat, exp_b2);
  endtask

  initial begin
    clr_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dw3", bus.deltaw3_flat, 0);
    chk("rst_db3", bus.deltab3_flat, 0);
    chk("rst_db2", bus.deltab2_flat, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    nominal_inputs();
    start_pass();
    chk("nom_busy", bus.busy, 1);
    bus.action  = 2'd2;
    bus.target  = 16'h1234;
    bus.a2_flat = {5{16'h0777}};
    bus.w3_flat = {20{16'h0333}};
    watch(10, -1, -1, -1, np, fe);
    chk("nom_pulses", 32'(np), 1);
    chk("nom_done_edge", 32'(fe), 7);
    chk("nom_idle", bus.busy, 0);
    chk_nominal("nom");

    clr_inputs();
    bus.action = 2'd3;
    bus.target = 16'd0;
    bus.lr     = 16'd1024;
    bus.a3_flat[48 +: 16]  = 16'd1024;
    bus.w3_flat[176 +: 16] = 16'd1024;
    start_pass();
    watch(8, -1, -1, -1, np, fe);
    chk("neg_db3", bus.deltab3_flat, {16'hfc00, 48'h0});
    chk("neg_db2_2", bus.deltab2_flat[32 +: 16], 0);
    chk("neg_dw3_23", dw3(2, 3), 0);
    chk("neg_dw3", bus.deltaw3_flat, 0);

    clr_inputs();
    bus.target = 16'h7fff;
    bus.lr     = 16'd1024;
    bus.a3_flat[0 +: 16] = 16'h8000;
    bus.a2_flat[0 +: 16] = 16'h7fff;
    start_pass();
    watch(8, -1, -1, -1, np, fe);
    chk("satp_db3", bus.deltab3_flat, 64'h7fff);
    chk("satp_dw3_00", dw3(0, 0), 16'h7fff);
    chk("satp_db2", bus.deltab2_flat, 0);

    bus.target = 16'h8000;
    bus.a3_flat[0 +: 16] = 16'h7fff;
    start_pass();
    watch(8, -1, -1, -1, np, fe);
    chk("satn_db3", bus.deltab3_flat, 64'h8000);
    chk("satn_dw3_00", dw3(0, 0), 16'h8000);

    nominal_inputs();
    start_pass();
    bus.action = 2'd0;
    watch(12, 3, 5, -1, np, fe);
    chk("busy_pulses", 32'(np), 1);
    chk("busy_done_edge", 32'(fe), 7);
    chk_nominal("busy");

    start_pass();
    watch(4, -1, -1, 4, np, fe);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_dw3", bus.deltaw3_flat, 0);
    chk("mrst_db3", bus.deltab3_flat, 0);
    chk("mrst_db2", bus.deltab2_flat, 0);
    watch(6, -1, -1, -1, np, fe);
    chk("mrst_pulses", 32'(np), 0);

    nominal_inputs();
    start_pass();
    watch(7, -1, -1, -1, np, fe);
    chk("fresh_done_edge", 32'(fe), 7);
    chk_nominal("fresh");

    clr_inputs();
    bus.action = 2'd2;
    bus.target = 16'd1024;
    bus.lr     = 16'd1024;
    bus.a2_flat[0 +: 16]  = 16'd1024;
    bus.w3_flat[32 +: 16] = 16'd1024;
    start_pass();
    chk("b2b_busy", bus.busy, 1);
    chk("b2b_clr_dw3", bus.deltaw3_flat, 0);
    chk("b2b_clr_db3", bus.deltab3_flat, 0);
    watch(10, -1, -1, -1, np, fe);
    chk("b2b_done_edge", 32'(fe), 7);
    chk("b2b_db3", bus.deltab3_flat, {16'h0, 16'd1024, 32'h0});
    exp_w3 = '0;
    exp_w3[32 +: 16] = 16'd1024;
    chk("b2b_dw3", bus.deltaw3_flat, exp_w3);
    chk("b2b_db2", bus.deltab2_flat, 80'd1024);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
